// File: rtl/block_dispatcher_if.sv
// Launch-side and MP-broadcast signals of the block dispatcher.
// The slave modport is the dispatcher; the master side is the scheduler/MP array.
interface block_dispatcher_if #(
    parameter int unsigned NUM_MPS      = 8,
    parameter int unsigned MPID_DEPTH   = $clog2(NUM_MPS),
    parameter int unsigned GRID_DIM     = 32,
    parameter int unsigned BLOCK_DIM    = 32,
    parameter int unsigned WARPID_DEPTH = 4,
    parameter int unsigned R_ADDR_WIDTH = 10
);
    logic                    launch;
    logic [GRID_DIM-1:0]     launch_gdim;
    logic [BLOCK_DIM-1:0]    launch_bdim;
    logic [WARPID_DEPTH-1:0] launch_warps;
    logic [R_ADDR_WIDTH-1:0] launch_regs;
    logic [NUM_MPS-1:0]      ready;
    logic                    busy;
    logic                    done;
    logic                    start;
    logic [MPID_DEPTH-1:0]   mpid;
    logic [GRID_DIM-1:0]     bidx;
    logic [GRID_DIM-1:0]     gdim;
    logic [BLOCK_DIM-1:0]    bdim;
    logic [WARPID_DEPTH-1:0] warp_o;
    logic [R_ADDR_WIDTH-1:0] reg_o;

    modport master (
        output launch, launch_gdim, launch_bdim, launch_warps, launch_regs, ready,
        input  busy, done, start, mpid, bidx, gdim, bdim, warp_o, reg_o
    );

    modport slave (
        input  launch, launch_gdim, launch_bdim, launch_warps, launch_regs, ready,
        output busy, done, start, mpid, bidx, gdim, bdim, warp_o, reg_o
    );
endinterface

// File: rtl/block_dispatcher.sv
// Walks a launch grid in x-then-y-then-z order and issues each block to a
// ready MP chosen round-robin, broadcasting the launch parameters to all MPs.
module block_dispatcher #(
    parameter int unsigned NUM_MPS        = 8,
    parameter int unsigned MPID_DEPTH     = $clog2(NUM_MPS),
    parameter int unsigned GRID_DIM       = 32,
    parameter int unsigned GRID_DIM_WIDTH = 10,
    parameter int unsigned BLOCK_DIM      = 32,
    parameter int unsigned WARPID_DEPTH   = 4,
    parameter int unsigned R_ADDR_WIDTH   = 10
) (
    input logic               clk,
    input logic               rst,
    block_dispatcher_if.slave bus
);
    localparam int unsigned W = GRID_DIM_WIDTH;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StCool  = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    logic [1:0]              state_q, state_d;
    logic [W-1:0]            x_q, x_d, y_q, y_d, z_q, z_d;
    logic [MPID_DEPTH-1:0]   rr_q, rr_d;
    logic                    start_q, start_d;
    logic                    done_q, done_d;
    logic                    busy_q, busy_d;
    logic [MPID_DEPTH-1:0]   mpid_q, mpid_d;
    logic [GRID_DIM-1:0]     bidx_q, bidx_d;
    logic [GRID_DIM-1:0]     gdim_q, gdim_d;
    logic [BLOCK_DIM-1:0]    bdim_q, bdim_d;
    logic [WARPID_DEPTH-1:0] warp_q, warp_d;
    logic [R_ADDR_WIDTH-1:0] reg_q, reg_d;

    logic [W-1:0]            gx, gy, gz;
    logic                    last_x, last_y, last_z;
    logic                    grant_found;
    logic [MPID_DEPTH-1:0]   grant;
    logic [31:0]             idx;

    assign gx = gdim_q[W-1:0];
    assign gy = gdim_q[2*W-1:W];
    assign gz = gdim_q[3*W-1:2*W];

    assign last_x = (x_q == gx - 1'b1);
    assign last_y = (y_q == gy - 1'b1);
    assign last_z = (z_q == gz - 1'b1);

    // First ready MP at or above rr_q, wrapping around the MP array.
    always_comb begin
        grant_found = 1'b0;
        grant       = '0;
        idx         = '0;
        for (int unsigned i = 0; i < NUM_MPS; i++) begin
            idx = (32'(rr_q) + i) % NUM_MPS;
            if (!grant_found && bus.ready[idx[MPID_DEPTH-1:0]]) begin
                grant_found = 1'b1;
                grant       = idx[MPID_DEPTH-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        rr_d    = rr_q;
        start_d = 1'b0;
        done_d  = 1'b0;
        mpid_d  = mpid_q;
        bidx_d  = bidx_q;
        gdim_d  = gdim_q;
        bdim_d  = bdim_q;
        warp_d  = warp_q;
        reg_d   = reg_q;

        unique case (state_q)
            StIdle: begin
                if (bus.launch) begin
                    gdim_d = bus.launch_gdim;
                    bdim_d = bus.launch_bdim;
                    warp_d = bus.launch_warps;
                    reg_d  = bus.launch_regs;
                    x_d    = '0;
                    y_d    = '0;
                    z_d    = '0;
                    if (bus.launch_gdim[W-1:0] == '0 || bus.launch_gdim[2*W-1:W] == '0 ||
                        bus.launch_gdim[3*W-1:2*W] == '0) begin
                        state_d = StDone;
                    end else begin
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                if (grant_found) begin
                    start_d                  = 1'b1;
                    mpid_d                   = grant;
                    bidx_d                   = '0;
                    bidx_d[3*W-1:0]          = {z_q, y_q, x_q};
                    rr_d = (32'(grant) == NUM_MPS - 1) ? '0 : grant + 1'b1;
                    if (last_x) begin
                        x_d = '0;
                        if (last_y) begin
                            y_d = '0;
                            z_d = z_q + 1'b1;
                        end else begin
                            y_d = y_q + 1'b1;
                        end
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                    state_d = (last_x && last_y && last_z) ? StDone : StCool;
                end
            end
            // Gives the granted MP a cycle to drop ready before re-arbitration.
            StCool: state_d = StIssue;
            StDone: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // busy stays up through the cycle that shows the done pulse.
        busy_d = (state_d != StIdle) || (state_q == StDone);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            rr_q    <= '0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            mpid_q  <= '0;
            bidx_q  <= '0;
            gdim_q  <= '0;
            bdim_q  <= '0;
            warp_q  <= '0;
            reg_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            rr_q    <= rr_d;
            start_q <= start_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            mpid_q  <= mpid_d;
            bidx_q  <= bidx_d;
            gdim_q  <= gdim_d;
            bdim_q  <= bdim_d;
            warp_q  <= warp_d;
            reg_q   <= reg_d;
        end
    end

    assign bus.start  = start_q;
    assign bus.done   = done_q;
    assign bus.busy   = busy_q;
    assign bus.mpid   = mpid_q;
    assign bus.bidx   = bidx_q;
    assign bus.gdim   = gdim_q;
    assign bus.bdim   = bdim_q;
    assign bus.warp_o = warp_q;
    assign bus.reg_o  = reg_q;
endmodule

// File: tb/tb_block_dispatcher.sv
// Self-checking bench for block_dispatcher: a grid-walk / round-robin model
// predicts every start, done and busy cycle; MPs are modelled per-cycle.
module tb_block_dispatcher;
    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    block_dispatcher_if bus ();

    block_dispatcher dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks   = 0;
    int          failures = 0;
    int          model_rr = 0;
    logic [2:0]  last_mp  = '0;
    logic [31:0] last_bidx = '0;
    logic [7:0]  cur_ready = '0;

    task automatic do_reset();
        bus.launch       = 1'b0;
        bus.launch_gdim  = '0;
        bus.launch_bdim  = '0;
        bus.launch_warps = '0;
        bus.launch_regs  = '0;
        cur_ready        = '0;
        bus.ready        = '0;
        rst              = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst       = 1'b1;
        model_rr  = 0;
        last_mp   = '0;
        last_bidx = '0;
    endtask

    task automatic test_reset();
        bus.launch = 1'b0;
        rst        = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({bus.start, bus.done, bus.busy} !== 3'b000 || bus.mpid !== '0 || bus.bidx !== '0 ||
            bus.gdim !== '0 || bus.bdim !== '0 || bus.warp_o !== '0 || bus.reg_o !== '0) begin
            failures++;
            $display("FAIL reset_outputs got start=%b done=%b busy=%b mpid=%0d bidx=%h gdim=%h exp all zero",
                     bus.start, bus.done, bus.busy, bus.mpid, bus.bidx, bus.gdim);
        end
        rst       = 1'b1;
        model_rr  = 0;
        last_mp   = '0;
        last_bidx = '0;
    endtask

    // One launch, checked cycle by cycle. rec>0: a granted MP drops ready one
    // cycle after start and re-raises it rec cycles later. abort_after>0: reset
    // is pulsed after that many starts.
    task automatic run_launch(input int gx, input int gy, input int gz, input logic [7:0] base,
                              input int rec, input bit relaunch, input int abort_after,
                              input string name);
        logic [31:0] g;
        logic [31:0] bd;
        logic [3:0]  wp;
        logic [9:0]  rg;
        logic [31:0] exp_q[$];
        int          drop_at[8];
        int          rise_at[8];
        int          k, done_k, last_start_k, nstart, abort_k, exp_mp;
        bit          exp_start, aborted;
        logic [7:0]  seen;

        g  = {2'b00, 10'(gz), 10'(gy), 10'(gx)};
        bd = $urandom;
        wp = 4'($urandom);
        rg = 10'($urandom);
        for (int z = 0; z < gz; z++)
            for (int y = 0; y < gy; y++)
                for (int x = 0; x < gx; x++)
                    exp_q.push_back({2'b00, 10'(z), 10'(y), 10'(x)});
        for (int i = 0; i < 8; i++) begin
            drop_at[i] = -1;
            rise_at[i] = -1;
        end
        done_k       = (exp_q.size() == 0) ? 2 : -1;
        last_start_k = -10;
        nstart       = 0;
        abort_k      = -1;
        aborted      = 1'b0;
        k            = 0;

        cur_ready        = base;
        bus.ready        = base;
        bus.launch       = 1'b1;
        bus.launch_gdim  = g;
        bus.launch_bdim  = bd;
        bus.launch_warps = wp;
        bus.launch_regs  = rg;

        while (k < 400) begin
            @(posedge clk);
            seen = cur_ready;
            #1;
            k++;
            if (aborted) begin
                checks++;
                if (k == abort_k + 1 &&
                    ({bus.start, bus.done, bus.busy} !== 3'b000 || bus.mpid !== '0 ||
                     bus.bidx !== '0 || bus.gdim !== '0 || bus.bdim !== '0 ||
                     bus.warp_o !== '0 || bus.reg_o !== '0)) begin
                    failures++;
                    $display("FAIL %s abort_zero got start=%b done=%b busy=%b mpid=%0d bidx=%h gdim=%h exp all zero",
                             name, bus.start, bus.done, bus.busy, bus.mpid, bus.bidx, bus.gdim);
                end else if ({bus.start, bus.done, bus.busy} !== 3'b000) begin
                    failures++;
                    $display("FAIL %s abort_quiet k=%0d got start=%b done=%b busy=%b exp 000",
                             name, k, bus.start, bus.done, bus.busy);
                end
                rst = 1'b1;
                if (k == abort_k + 3) break;
                continue;
            end

            exp_start = (k >= 2) && (k != last_start_k + 1) && (exp_q.size() > 0) && (seen != 0);
            checks++;
            if (bus.start !== exp_start) begin
                failures++;
                $display("FAIL %s start k=%0d got=%b exp=%b ready=%h", name, k, bus.start,
                         exp_start, seen);
            end
            if (exp_start) begin
                exp_mp = -1;
                for (int j = 0; j < 8; j++) begin
                    int c;
                    c = (model_rr + j) % 8;
                    if (exp_mp < 0 && seen[c]) exp_mp = c;
                end
                checks++;
                if (bus.mpid !== 3'(exp_mp) || bus.bidx !== exp_q[0]) begin
                    failures++;
                    $display("FAIL %s grant k=%0d got mpid=%0d bidx=%h exp mpid=%0d bidx=%h",
                             name, k, bus.mpid, bus.bidx, exp_mp, exp_q[0]);
                end
                last_mp      = 3'(exp_mp);
                last_bidx    = exp_q.pop_front();
                model_rr     = (exp_mp + 1) % 8;
                last_start_k = k;
                nstart++;
                if (rec > 0) begin
                    drop_at[exp_mp] = k + 1;
                    rise_at[exp_mp] = k + 1 + rec;
                end
                if (exp_q.size() == 0) done_k = k + 1;
            end else begin
                checks++;
                if (bus.mpid !== last_mp || bus.bidx !== last_bidx) begin
                    failures++;
                    $display("FAIL %s hold k=%0d got mpid=%0d bidx=%h exp mpid=%0d bidx=%h",
                             name, k, bus.mpid, bus.bidx, last_mp, last_bidx);
                end
            end
            checks++;
            if (bus.done !== (k == done_k)) begin
                failures++;
                $display("FAIL %s done k=%0d got=%b exp=%b", name, k, bus.done, (k == done_k));
            end
            checks++;
            if (bus.busy !== (done_k < 0 || k <= done_k)) begin
                failures++;
                $display("FAIL %s busy k=%0d got=%b exp=%b", name, k, bus.busy,
                         (done_k < 0 || k <= done_k));
            end
            if (done_k < 0 || k <= done_k) begin
                checks++;
                if (bus.gdim !== g || bus.bdim !== bd || bus.warp_o !== wp || bus.reg_o !== rg) begin
                    failures++;
                    $display("FAIL %s latched k=%0d got gdim=%h bdim=%h warp=%h reg=%h exp %h %h %h %h",
                             name, k, bus.gdim, bus.bdim, bus.warp_o, bus.reg_o, g, bd, wp, rg);
                end
            end
            if (done_k > 0 && k == done_k + 1) break;

            if (k == 1) bus.launch = 1'b0;
            if (relaunch && k == 3) begin
                bus.launch       = 1'b1;
                bus.launch_gdim  = {2'b00, 10'd2, 10'd3, 10'd5};
                bus.launch_bdim  = ~bd;
                bus.launch_warps = ~wp;
                bus.launch_regs  = ~rg;
            end
            if (relaunch && k == 4) bus.launch = 1'b0;
            for (int i = 0; i < 8; i++) begin
                if (k == drop_at[i]) cur_ready[i] = 1'b0;
                if (k == rise_at[i]) cur_ready[i] = base[i];
            end
            bus.ready = cur_ready;
            if (abort_after > 0 && nstart == abort_after) begin
                rst       = 1'b0;
                aborted   = 1'b1;
                abort_k   = k;
                model_rr  = 0;
                last_mp   = '0;
                last_bidx = '0;
            end
        end
        bus.launch = 1'b0;
        checks++;
        if (k >= 400) begin
            failures++;
            $display("FAIL %s timeout got k=%0d exp completion under 400 cycles", name, k);
        end
    endtask

    task automatic test_single();
        run_launch(1, 1, 1, 8'hFF, 0, 1'b0, 0, "single_1x1x1");
    endtask

    task automatic test_grid_2x2();
        do_reset();
        run_launch(2, 2, 1, 8'hFF, 0, 1'b0, 0, "grid_2x2x1");
    endtask

    task automatic test_single_mp_backpressure();
        run_launch(3, 1, 1, 8'h20, 4, 1'b0, 0, "mp5_only");
    endtask

    task automatic test_zero_dim();
        run_launch(3, 0, 2, 8'hFF, 0, 1'b0, 0, "zero_y");
        run_launch(0, 4, 4, 8'hFF, 0, 1'b0, 0, "zero_x");
    endtask

    task automatic test_relaunch_ignored();
        run_launch(4, 1, 1, 8'hFF, 0, 1'b1, 0, "relaunch_4x1x1");
    endtask

    task automatic test_abort();
        run_launch(4, 1, 1, 8'hFF, 0, 1'b0, 2, "abort_4x1x1");
        run_launch(1, 1, 1, 8'hFF, 0, 1'b0, 0, "after_abort_1x1x1");
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            run_launch($urandom_range(1, 3), $urandom_range(1, 3), $urandom_range(1, 3),
                       8'($urandom_range(1, 255)), $urandom_range(0, 5), 1'b0, 0, "random");
        end
    endtask

    initial begin
        do_reset();
        test_reset();
        test_single();
        test_grid_2x2();
        test_single_mp_backpressure();
        test_zero_dim();
        test_relaunch_ignored();
        test_abort();
        test_random();
        test_back_to_back_reset_check();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    task automatic test_back_to_back_reset_check();
        test_reset();
        run_launch(2, 1, 1, 8'h81, 0, 1'b0, 0, "post_reset_wrap");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got no finish exp finish before time limit");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/block_dispatcher.md
# block_dispatcher

Distributes the thread blocks of one kernel launch across the multiprocessors. It sits between the kernel-launch control of the global scheduler and the MP array. It walks the grid index space in x-then-y-then-z order and grants each block to a ready MP by round-robin. It drives the shared start/mpid/bidx/bdim/gdim/warp/reg broadcast consumed by every MP.

## Interface
- NUM_MPS, 8, number of multiprocessors
- MPID_DEPTH, $clog2(NUM_MPS), bits per MP id
- GRID_DIM, 32, packed grid/index word width
- GRID_DIM_WIDTH, 10, bits per grid dimension
- BLOCK_DIM, 32, packed block-dim word width
- WARPID_DEPTH, 4, bits in warp count
- R_ADDR_WIDTH, 10, bits in per-thread register count
- clk  input  1  clock; the block uses this single clock
- rst  input  1  reset; synchronous, active-low
- launch  input  1  one-cycle launch request
- launch_gdim  input  GRID_DIM  grid dims: x [9:0], y [19:10], z [29:20], [31:30] zero
- launch_bdim  input  BLOCK_DIM  block dims, passed through
- launch_warps  input  WARPID_DEPTH  warps per block
- launch_regs  input  R_ADDR_WIDTH  registers per thread
- ready  input  NUM_MPS  per-MP "can accept a block"
- busy  output  1  launch in progress
- done  output  1  one-cycle pulse: all blocks issued
- start  output  1  one-cycle block-issue pulse
- mpid  output  MPID_DEPTH  target MP of start
- bidx  output  GRID_DIM  block index, packed like gdim
- gdim, bdim, warp_o, reg_o  output  GRID_DIM/BLOCK_DIM/WARPID_DEPTH/R_ADDR_WIDTH  launch values held while busy

## Operation
- FSM states are IDLE, ISSUE, COOL and DONE. All outputs are registered.
- IDLE:
  - On launch=1, latch launch_* into gdim/bdim/warp_o/reg_o and clear the internal index counters to (0,0,0).
  - If any of x, y or z is 0, go to DONE. No start is issued.
  - Otherwise go to ISSUE.
  - launch is ignored in every state except IDLE.
- ISSUE:
  - Eligible MPs are those with ready[i]=1.
  - If none are eligible, stay in ISSUE.
  - Otherwise grant the first eligible MP, searching upward from rr_ptr with wrap-around.
  - Register start=1, mpid=grant and bidx={2'b0,z,y,x}.
  - Set rr_ptr to grant+1, wrapping at NUM_MPS.
  - Advance the index: x+1. When x wraps at gdim.x, x=0 and y+1. When y wraps at gdim.y, y=0 and z+1.
  - If the issued index was the last one (x=X-1, y=Y-1, z=Z-1), go to DONE. Otherwise go to COOL.
- COOL:
  - Lasts one cycle, then returns to ISSUE.
  - This guarantees that the granted MP has dropped ready before the next arbitration. MPs deassert ready the cycle after sampling start.
- DONE:
  - Register done=1, then go to IDLE.
- busy=1 in ISSUE, COOL and DONE, and 0 in IDLE.
- rr_ptr persists across launches and resets to 0.
- Reset, checked every cycle with priority over everything:
  - State returns to IDLE.
  - start, done, busy, mpid, bidx, gdim, bdim, warp_o, reg_o and rr_ptr all go to 0.
  - Any in-progress launch is abandoned with no done pulse.
- Index counters are GRID_DIM_WIDTH bits each. Comparison is against the latched dims, so dims up to 1023 are supported and there is no overflow.

## Timing
- Cycle T: launch=1 sampled in IDLE. Cycle T+1: busy=1.
- An ISSUE cycle N with some ready[i]=1 produces start/mpid/bidx visible in cycle N+1, high for exactly one cycle. Maximum issue rate is one block per 2 cycles.
- The last block's start is visible in cycle M. done=1 is visible in cycle M+1, and busy=0 in cycle M+2.
- Zero-dim launch at T: done=1 in cycle T+2, busy=0 in cycle T+3, start never asserted.
- mpid and bidx hold their values when start=0.
- ready is only sampled in ISSUE.

## Test plan
- gdim x=1,y=1,z=1, ready=8'hFF, launch at T → exactly one start in cycle T+2 with mpid=0 and bidx=0; done in cycle T+3; busy=0 in cycle T+4.
- gdim 2x2x1, ready=8'hFF, rr_ptr=0 → starts on cycles T+2, T+4, T+6 and T+8; mpid 0,1,2,3; bidx 0x000, 0x001, 0x400, 0x401.
- gdim 3x1x1, ready=8'h20 held, with the bench modelling MP5 dropping ready one cycle after start and re-raising it 4 cycles later → all three starts go to mpid=5; no start while ready=0; bidx x=0,1,2.
- gdim y=0 → no start; done pulses once; busy is high for exactly 2 cycles.
- During a 4x1x1 launch, assert launch again with different dims → ignored; the latched gdim is unchanged; exactly four starts occur.
- rst=0 after the second start of a 4x1x1 launch → next cycle all outputs are 0 and the state is IDLE; no done pulse; a fresh 1x1x1 launch then issues mpid=0.
